sensor_hit_qualifier: RTL and testbench
=======================================

# sensor_hit_qualifier

Upstream stage of the game datapath. Converts the raw 3-bit box address from the Arduino sensor bus (GPIO_1) into clean, single-cycle hit/miss events. It synchronises and debounces the bus, then compares each settled strike against the current LFSR target. A lockout window prevents one physical strike from scoring repeatedly, so the datapath's score counter and sound trigger consume exactly one event per strike.

## Interface
- DEBOUNCE_CYCLES, 500000: cycles the synchronised bus must hold a value before it is accepted (10 ms at 50 MHz); legal range ≥2.
- LOCKOUT_CYCLES, 25000000: minimum cycles after an event before the next event may be accepted (0.5 s); legal range ≥2.
- CLOCK_50  in  1  system clock, 50 MHz; the only clock.
- resetn  in  1  reset, asynchronous, active-low.
- enable  in  1  game running (driven from start_game); low forces IDLE.
- sensor_raw  in  3  raw box address from GPIO_1; asynchronous; 3'b000 = no box struck.
- target  in  3  current LFSR box address; synchronous, sampled only at event time.
- hit_pulse  out  1  one-cycle pulse: settled strike equals target.
- miss_pulse  out  1  one-cycle pulse: settled strike differs from target.
- hit_box  out  3  settled address of the last event; holds until the next event.
- busy  out  1  high in REPORT, LOCKOUT and RELEASE.

## Operation
- Synchroniser: 2-flop chain on sensor_raw → sync.
- Debouncer:
  - If sync ≠ cand: cand ← sync, cnt ← 0.
  - Else if cnt < DEBOUNCE_CYCLES-1: cnt ← cnt+1.
  - Else: stable ← cand.
  - cnt saturates at DEBOUNCE_CYCLES-1; width $clog2(DEBOUNCE_CYCLES).
  - Runs regardless of enable or FSM state.
- FSM states and transitions:
  - IDLE → ARMED when enable=1 and stable=000.
  - ARMED → REPORT when stable≠000. In the transition cycle: capture hit_box ← stable and latch hit = (stable == target) and (target ≠ 000).
  - REPORT (1 cycle): asserts hit_pulse=hit and miss_pulse=!hit; then LOCKOUT with lcnt ← 0.
  - LOCKOUT: lcnt increments; → RELEASE at lcnt = LOCKOUT_CYCLES-1. lcnt width is $clog2(LOCKOUT_CYCLES).
  - RELEASE → ARMED when stable=000. Each event needs the mallet lifted.
  - Any state → IDLE in the cycle after enable=0. A pending REPORT is suppressed: no pulse.
- hit_pulse and miss_pulse are registered, mutually exclusive, and never high for two consecutive cycles.
- Target 000 never matches, so any strike against it is a miss.
- A strike held across enable rising is not reported; IDLE waits for stable=000 first.
- A bus change to another non-zero address during LOCKOUT/RELEASE generates no event.

## Timing
- Reset values:
  - hit_pulse=0, miss_pulse=0, busy=0, hit_box=000.
  - state=IDLE; sync, cand and stable = 000; cnt=0; lcnt=0.
- Raw-to-event latency: sensor_raw sampled at edge k with a new value (held stable) → stable updates at edge k+DEBOUNCE_CYCLES+2 → pulse high for the cycle following edge k+DEBOUNCE_CYCLES+4. This assumes ARMED.
- Glitches shorter than DEBOUNCE_CYCLES (post-sync) never change stable.
- Minimum event spacing: 1 + LOCKOUT_CYCLES + release-debounce cycles.
- resetn assertion mid-LOCKOUT clears all state immediately (asynchronously). After deassertion: IDLE, no spurious pulse.
- target may change on any cycle; only the value at the ARMED→REPORT edge matters.

## Structure
- Shared package bytebasher_pkg:
  - NO_BOX = 3'b000.
  - BOX_W = 3.
  - qual_state_t enum {IDLE, ARMED, REPORT, LOCKOUT, RELEASE}.
  - Default DEBOUNCE/LOCKOUT constants derived from CLK_HZ = 50_000_000.
- Sub-module sensor_debouncer (parameter DEBOUNCE_CYCLES; ports CLOCK_50, resetn, raw[2:0], stable[2:0]): holds the synchroniser and debounce counter.
- The top level holds the FSM, lockout counter and compare.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, LOCKOUT_CYCLES=8.
- Clean hit: enable=1, target=3'b101, raw 000→101 held 20 cycles → one hit_pulse, 8 cycles after the change edge; hit_box=101; busy high from that cycle.
- Miss: target=3'b010, raw→001 → one miss_pulse, hit_box=001, no hit_pulse.
- Glitch rejection: raw=011 for 3 cycles, then 000 → no pulse; stable stays 000.
- Lockout/release:
  - Hold 101 for 40 cycles → exactly one pulse.
  - Drop to 000, then 101 again → second pulse only after RELEASE has seen stable=000.
  - busy low between release and the second strike.
- Target 000: target=000, raw→100 → miss_pulse.
- Abort and reset:
  - enable drops during the debounce of 110 → no pulse, state IDLE.
  - resetn pulsed low mid-LOCKOUT → all outputs 0 at once; no pulse after release until a fresh 000→non-zero strike.

Source files
------------

// File: rtl/bytebasher_pkg.sv
// Shared types and constants for the sensor-to-score datapath.
package bytebasher_pkg;

    localparam int BOX_W = 3;
    localparam logic [BOX_W-1:0] NO_BOX = 3'b000;

    localparam int CLK_HZ = 50_000_000;
    localparam int DEF_DEBOUNCE_CYCLES = CLK_HZ / 100;  // 10 ms
    localparam int DEF_LOCKOUT_CYCLES  = CLK_HZ / 2;    // 0.5 s

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        REPORT,
        LOCKOUT,
        RELEASE
    } qual_state_t;

    function automatic logic is_box(input logic [BOX_W-1:0] addr);
        return addr != NO_BOX;
    endfunction

endpackage

// File: rtl/sensor_debouncer.sv
// Two-flop synchroniser on the raw sensor bus followed by a hold-time debouncer.
module sensor_debouncer
    import bytebasher_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic             CLOCK_50,
    input  logic             resetn,
    input  logic [BOX_W-1:0] raw,
    output logic [BOX_W-1:0] stable
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [BOX_W-1:0] r_sync1;
    logic [BOX_W-1:0] r_sync2;
    logic [BOX_W-1:0] r_cand;
    logic [BOX_W-1:0] r_stable;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_sync1  <= NO_BOX;
            r_sync2  <= NO_BOX;
            r_cand   <= NO_BOX;
            r_stable <= NO_BOX;
            r_cnt    <= '0;
        end else begin
            r_sync1 <= raw;
            r_sync2 <= r_sync1;
            // Any change restarts the hold count; the counter saturates once settled.
            if (r_sync2 != r_cand) begin
                r_cand <= r_sync2;
                r_cnt  <= '0;
            end else if (r_cnt < CNT_MAX) begin
                r_cnt <= r_cnt + 1'b1;
            end else begin
                r_stable <= r_cand;
            end
        end
    end

    assign stable = r_stable;

endmodule

// File: rtl/sensor_hit_qualifier.sv
// Turns debounced sensor strikes into single-cycle hit/miss events with a
// post-event lockout and a mandatory mallet-lift between events.
//
//   state   | meaning
//   IDLE    | game stopped, or waiting for the bus to read NO_BOX
//   ARMED   | ready; next settled non-zero address is an event
//   REPORT  | one cycle; hit/miss pulse is registered from here
//   LOCKOUT | ignore the bus for LOCKOUT_CYCLES
//   RELEASE | wait for the mallet to be lifted (stable = NO_BOX)
module sensor_hit_qualifier
    import bytebasher_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int LOCKOUT_CYCLES  = DEF_LOCKOUT_CYCLES
) (
    input  logic             CLOCK_50,
    input  logic             resetn,
    input  logic             enable,
    input  logic [BOX_W-1:0] sensor_raw,
    input  logic [BOX_W-1:0] target,
    output logic             hit_pulse,
    output logic             miss_pulse,
    output logic [BOX_W-1:0] hit_box,
    output logic             busy
);

    localparam int LCNT_W = $clog2(LOCKOUT_CYCLES);
    localparam logic [LCNT_W-1:0] LCNT_MAX = LCNT_W'(LOCKOUT_CYCLES - 1);

    logic [BOX_W-1:0]  w_stable;
    qual_state_t       r_state;
    qual_state_t       w_next;
    logic              w_capture;
    logic [LCNT_W-1:0] r_lcnt;
    logic              r_hit;
    logic [BOX_W-1:0]  r_hit_box;
    logic              r_hit_pulse;
    logic              r_miss_pulse;
    logic              r_busy;

    sensor_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
        .CLOCK_50(CLOCK_50),
        .resetn  (resetn),
        .raw     (sensor_raw),
        .stable  (w_stable)
    );

    always_comb begin
        w_next    = r_state;
        w_capture = 1'b0;
        unique case (r_state)
            IDLE:    if (!is_box(w_stable)) w_next = ARMED;
            ARMED: begin
                if (is_box(w_stable)) begin
                    w_next    = REPORT;
                    w_capture = 1'b1;
                end
            end
            REPORT:  w_next = LOCKOUT;
            LOCKOUT: if (r_lcnt == LCNT_MAX) w_next = RELEASE;
            RELEASE: if (!is_box(w_stable)) w_next = ARMED;
            default: w_next = IDLE;
        endcase
        if (!enable) begin
            w_next    = IDLE;
            w_capture = 1'b0;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_state      <= IDLE;
            r_lcnt       <= '0;
            r_hit        <= 1'b0;
            r_hit_box    <= NO_BOX;
            r_hit_pulse  <= 1'b0;
            r_miss_pulse <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_capture) begin
                r_hit_box <= w_stable;
                r_hit     <= (w_stable == target) && is_box(target);
            end
            r_lcnt <= (r_state == LOCKOUT) ? r_lcnt + 1'b1 : '0;
            // Gating with enable drops a REPORT that is being aborted.
            r_hit_pulse  <= (r_state == REPORT) && enable && r_hit;
            r_miss_pulse <= (r_state == REPORT) && enable && !r_hit;
            r_busy       <= (r_state == REPORT) || (r_state == LOCKOUT) || (r_state == RELEASE);
        end
    end

    assign hit_pulse  = r_hit_pulse;
    assign miss_pulse = r_miss_pulse;
    assign hit_box    = r_hit_box;
    assign busy       = r_busy;

endmodule

// File: tb/tb_sensor_hit_qualifier.sv
// Self-checking bench for sensor_hit_qualifier against an event-level timestamp model.
module tb_sensor_hit_qualifier;

    localparam int D = 4;
    localparam int L = 8;

    logic       clk = 1'b0;
    logic       rstn;
    logic       enable;
    logic [2:0] raw;
    logic [2:0] target;
    logic       hit_pulse;
    logic       miss_pulse;
    logic [2:0] hit_box;
    logic       busy;

    int checks = 0;
    int errors = 0;

    // reference model
    int         cyc;
    logic [2:0] rawq[$];
    logic [2:0] m_stable;
    int         m_mode;      // 0 stopped/awaiting lift, 1 ready, 2 event in progress
    int         m_ev;
    bit         m_ev_hit;
    logic       exp_hit, exp_miss, exp_busy;
    logic [2:0] exp_box;

    sensor_hit_qualifier #(
        .DEBOUNCE_CYCLES(D),
        .LOCKOUT_CYCLES (L)
    ) dut (
        .CLOCK_50  (clk),
        .resetn    (rstn),
        .enable    (enable),
        .sensor_raw(raw),
        .target    (target),
        .hit_pulse (hit_pulse),
        .miss_pulse(miss_pulse),
        .hit_box   (hit_box),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        cyc = 0;
        rawq.delete();
        for (int i = 0; i < D + 3; i++) rawq.push_back(3'b000);
        m_stable = 3'b000;
        m_mode   = 0;
        m_ev     = -100;
        m_ev_hit = 1'b0;
        exp_hit  = 1'b0;
        exp_miss = 1'b0;
        exp_busy = 1'b0;
        exp_box  = 3'b000;
    endtask

    // One clock edge: the bus value becomes settled once D+1 consecutive samples agree.
    task automatic model_step();
        bit nh, nm, nb, same;
        cyc++;
        nh = (m_mode == 2) && (cyc == m_ev + 1) && enable && m_ev_hit;
        nm = (m_mode == 2) && (cyc == m_ev + 1) && enable && !m_ev_hit;
        nb = (m_mode == 2);
        if (!enable) m_mode = 0;
        else if (m_mode == 0) begin
            if (m_stable == 3'b000) m_mode = 1;
        end else if (m_mode == 1) begin
            if (m_stable != 3'b000) begin
                m_mode   = 2;
                m_ev     = cyc;
                m_ev_hit = (m_stable == target) && (target != 3'b000);
                exp_box  = m_stable;
            end
        end else if (cyc >= m_ev + L + 2 && m_stable == 3'b000) begin
            m_mode = 1;
        end
        rawq.push_back(raw);
        void'(rawq.pop_front());
        same = 1'b1;
        for (int i = 1; i <= D; i++) if (rawq[i] != rawq[0]) same = 1'b0;
        if (same) m_stable = rawq[D];
        exp_hit  = nh;
        exp_miss = nm;
        exp_busy = nb;
    endtask

    task automatic tick();
        @(posedge clk);
        if (rstn) model_step();
        else model_reset();
        @(negedge clk);
    endtask

    task automatic idle_ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        rstn = 1'b0; enable = 1'b0; raw = 3'b000; target = 3'b000;
        model_reset();
        #1;
        checks++;
        if ({hit_pulse, miss_pulse, busy, hit_box} !== 6'b0) begin
            errors++;
            $display("FAIL reset_async got %b%b%b %b required 000 000", hit_pulse, miss_pulse, busy, hit_box);
        end
        idle_ticks(3);
        checks++;
        if ({hit_pulse, miss_pulse, busy, hit_box} !== 6'b0) begin
            errors++;
            $display("FAIL reset_held got %b%b%b %b required 000 000", hit_pulse, miss_pulse, busy, hit_box);
        end
        rstn = 1'b1;
        enable = 1'b1;
        idle_ticks(4);
    endtask

    task automatic test_clean_hit();
        int first, hits, misses;
        bit busy_at;
        first = -1; hits = 0; misses = 0; busy_at = 1'b0;
        target = 3'b101;
        raw = 3'b101;
        for (int i = 1; i <= 20; i++) begin
            tick();
            checks++;
            if ({hit_pulse, miss_pulse, busy, hit_box} !== {exp_hit, exp_miss, exp_busy, exp_box}) begin
                errors++;
                $display("FAIL clean_hit_cycle%0d got %b%b%b %b required %b%b%b %b", i,
                         hit_pulse, miss_pulse, busy, hit_box, exp_hit, exp_miss, exp_busy, exp_box);
            end
            if (hit_pulse) begin
                hits++;
                if (first < 0) begin first = i; busy_at = busy; end
            end
            if (miss_pulse) misses++;
        end
        checks++;
        if (hits != 1 || misses != 0) begin
            errors++;
            $display("FAIL clean_hit_count got hits=%0d misses=%0d required 1 0", hits, misses);
        end
        checks++;
        if (first != 9) begin
            errors++;
            $display("FAIL clean_hit_latency got %0d required 9", first);
        end
        checks++;
        if (hit_box !== 3'b101 || busy_at !== 1'b1) begin
            errors++;
            $display("FAIL clean_hit_box got box=%b busy=%b required 101 1", hit_box, busy_at);
        end
        raw = 3'b000;
        idle_ticks(30);
    endtask

    task automatic test_miss();
        int hits, misses;
        hits = 0; misses = 0;
        target = 3'b010;
        raw = 3'b001;
        for (int i = 1; i <= 20; i++) begin
            tick();
            checks++;
            if ({hit_pulse, miss_pulse, busy, hit_box} !== {exp_hit, exp_miss, exp_busy, exp_box}) begin
                errors++;
                $display("FAIL miss_cycle%0d got %b%b%b %b required %b%b%b %b", i,
                         hit_pulse, miss_pulse, busy, hit_box, exp_hit, exp_miss, exp_busy, exp_box);
            end
            hits += int'(hit_pulse);
            misses += int'(miss_pulse);
        end
        checks++;
        if (hits != 0 || misses != 1 || hit_box !== 3'b001) begin
            errors++;
            $display("FAIL miss_event got hits=%0d misses=%0d box=%b required 0 1 001", hits, misses, hit_box);
        end
        raw = 3'b000;
        idle_ticks(30);
    endtask

    task automatic test_glitch();
        int pulses, g;
        pulses = 0;
        g = $urandom_range(1, 3);
        target = 3'b011;
        raw = 3'b011;
        for (int i = 1; i <= g + 14; i++) begin
            if (i == g + 1) raw = 3'b000;
            tick();
            checks++;
            if ({hit_pulse, miss_pulse, busy, hit_box} !== {exp_hit, exp_miss, exp_busy, exp_box}) begin
                errors++;
                $display("FAIL glitch_cycle%0d got %b%b%b %b required %b%b%b %b", i,
                         hit_pulse, miss_pulse, busy, hit_box, exp_hit, exp_miss, exp_busy, exp_box);
            end
            pulses += int'(hit_pulse) + int'(miss_pulse);
        end
        checks++;
        if (pulses != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL glitch_reject len=%0d got pulses=%0d busy=%b required 0 0", g, pulses, busy);
        end
    endtask

    task automatic test_lockout_release();
        int p1, p2;
        bit saw_low;
        p1 = 0; p2 = 0; saw_low = 1'b0;
        target = 3'(1 + $urandom_range(0, 6));
        raw = 3'b101;
        for (int i = 1; i <= 40; i++) begin
            tick();
            checks++;
            if ({hit_pulse, miss_pulse, busy, hit_box} !== {exp_hit, exp_miss, exp_busy, exp_box}) begin
                errors++;
                $display("FAIL lockout_hold%0d got %b%b%b %b required %b%b%b %b", i,
                         hit_pulse, miss_pulse, busy, hit_box, exp_hit, exp_miss, exp_busy, exp_box);
            end
            p1 += int'(hit_pulse) + int'(miss_pulse);
        end
        checks++;
        if (p1 != 1) begin
            errors++;
            $display("FAIL lockout_single got pulses=%0d required 1", p1);
        end
        raw = 3'b000;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (!busy) saw_low = 1'b1;
        end
        checks++;
        if (!saw_low || busy !== 1'b0) begin
            errors++;
            $display("FAIL release_busy got saw_low=%b busy=%b required 1 0", saw_low, busy);
        end
        raw = 3'b101;
        for (int i = 1; i <= 20; i++) begin
            tick();
            checks++;
            if ({hit_pulse, miss_pulse, busy, hit_box} !== {exp_hit, exp_miss, exp_busy, exp_box}) begin
                errors++;
                $display("FAIL lockout_second%0d got %b%b%b %b required %b%b%b %b", i,
                         hit_pulse, miss_pulse, busy, hit_box, exp_hit, exp_miss, exp_busy, exp_box);
            end
            p2 += int'(hit_pulse) + int'(miss_pulse);
        end
        checks++;
        if (p2 != 1) begin
            errors++;
            $display("FAIL lockout_second_event got pulses=%0d required 1", p2);
        end
        raw = 3'b000;
        idle_ticks(30);
    endtask

    task automatic test_target_zero();
        int hits, misses;
        hits = 0; misses = 0;
        target = 3'b000;
        raw = 3'b100;
        for (int i = 1; i <= 20; i++) begin
            tick();
            hits += int'(hit_pulse);
            misses += int'(miss_pulse);
        end
        checks++;
        if (hits != 0 || misses != 1 || hit_box !== 3'b100) begin
            errors++;
            $display("FAIL target_zero got hits=%0d misses=%0d box=%b required 0 1 100", hits, misses, hit_box);
        end
        raw = 3'b000;
        idle_ticks(30);
    endtask

    task automatic test_abort();
        int pulses;
        pulses = 0;
        target = 3'b110;
        raw = 3'b110;
        for (int i = 1; i <= 48; i++) begin
            if (i == 4) enable = 1'b0;
            if (i == 19) enable = 1'b1;
            if (i == 34) raw = 3'b000;
            tick();
            checks++;
            if ({hit_pulse, miss_pulse, busy, hit_box} !== {exp_hit, exp_miss, exp_busy, exp_box}) begin
                errors++;
                $display("FAIL abort_cycle%0d got %b%b%b %b required %b%b%b %b", i,
                         hit_pulse, miss_pulse, busy, hit_box, exp_hit, exp_miss, exp_busy, exp_box);
            end
            pulses += int'(hit_pulse) + int'(miss_pulse);
        end
        checks++;
        if (pulses != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_no_event got pulses=%0d busy=%b required 0 0", pulses, busy);
        end
    endtask

    task automatic test_reset_mid_lockout();
        int pulses, waited;
        pulses = 0; waited = 0;
        target = 3'b011;
        raw = 3'b011;
        while (!hit_pulse && waited < 30) begin
            tick();
            waited++;
        end
        checks++;
        if (!hit_pulse) begin
            errors++;
            $display("FAIL midlock_setup got no hit_pulse within %0d cycles required 1", waited);
        end
        idle_ticks(3);
        #2;
        rstn = 1'b0;
        raw = 3'b000;
        model_reset();
        #1;
        checks++;
        if ({hit_pulse, miss_pulse, busy, hit_box} !== 6'b0) begin
            errors++;
            $display("FAIL midlock_async got %b%b%b %b required 000 000", hit_pulse, miss_pulse, busy, hit_box);
        end
        idle_ticks(3);
        rstn = 1'b1;
        for (int i = 1; i <= 35; i++) begin
            if (i == 16) raw = 3'b011;
            tick();
            checks++;
            if ({hit_pulse, miss_pulse, busy, hit_box} !== {exp_hit, exp_miss, exp_busy, exp_box}) begin
                errors++;
                $display("FAIL midlock_after%0d got %b%b%b %b required %b%b%b %b", i,
                         hit_pulse, miss_pulse, busy, hit_box, exp_hit, exp_miss, exp_busy, exp_box);
            end
            if (i < 16) pulses += int'(hit_pulse) + int'(miss_pulse);
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL midlock_spurious got pulses=%0d required 0", pulses);
        end
        raw = 3'b000;
        idle_ticks(30);
    endtask

    task automatic test_random();
        int hold, events;
        hold = 0; events = 0;
        for (int i = 1; i <= 600; i++) begin
            if (hold == 0) begin
                raw  = ($urandom_range(0, 2) == 0) ? 3'b000 : 3'($urandom_range(0, 7));
                hold = $urandom_range(1, 14);
            end
            hold--;
            if ($urandom_range(0, 3) == 0) target = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 59) == 0) enable = ~enable;
            tick();
            checks++;
            if ({hit_pulse, miss_pulse, busy, hit_box} !== {exp_hit, exp_miss, exp_busy, exp_box}) begin
                errors++;
                $display("FAIL random_cycle%0d got %b%b%b %b required %b%b%b %b", i,
                         hit_pulse, miss_pulse, busy, hit_box, exp_hit, exp_miss, exp_busy, exp_box);
            end
            events += int'(exp_hit) + int'(exp_miss);
        end
        checks++;
        if (events == 0) begin
            errors++;
            $display("FAIL random_activity got events=%0d required >0", events);
        end
        enable = 1'b1;
        raw = 3'b000;
        idle_ticks(30);
    endtask

    initial begin
        test_reset();
        test_clean_hit();
        test_miss();
        test_glitch();
        test_lockout_release();
        test_target_zero();
        test_abort();
        test_reset_mid_lockout();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
